// File: rtl/seq_gen.sv
// Purpose : serial pattern generator, sends a WIDTH-bit pattern MSB first, repeated max(count,1) times.
// Latency : first bit on dout one cycle after the start edge; done pulses one cycle after the last bit.
// Backpr. : none; start is accepted only in IDLE, abort cancels SHIFT/GAP, busy flags that start is ignored.
//
// Ports
//   clk        : single clock, all state changes on its rising edge
//   rst        : synchronous active-high reset
//   start      : begin transmission (sampled only in IDLE; abort wins when both high)
//   use_def    : at start, 1 selects DEF_PAT, 0 selects pattern
//   pattern    : WIDTH-bit pattern to send, MSB first
//   count      : repetitions, 0 is treated as 1
//   abort      : cancels transmission in SHIFT or GAP, no done pulse
//   dout       : serial data bit (0 whenever dout_valid is low)
//   dout_valid : dout carries a pattern bit this cycle
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse after the last bit of the last repetition
//
// Build option
//   SEQ_GEN_GAP_EN : when defined, a one-cycle GAP state separates consecutive
//                    repetitions; when undefined, repetitions are back-to-back.
//
// All outputs are decoded from registered state only (Moore machine), so no
// input has a combinational path to any output.

module seq_gen #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] DEF_PAT = 8'b1010_1010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       count,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    // Bit counter must hold WIDTH-1; keep at least one bit for WIDTH=2.
    localparam int            BW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SEQ_GEN_GAP_EN
        ST_GAP   = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;   // bits still to send in this repetition
    logic [WIDTH-1:0] hold_q,  hold_d;    // copy of the latched pattern for reloads
    logic [3:0]       rep_q,   rep_d;     // repetitions remaining, including the current one
    logic [BW-1:0]    bit_q,   bit_d;     // bits remaining in this repetition minus one

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
            rep_q   <= rep_d;
            bit_q   <= bit_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        bit_d   = bit_q;

        case (state_q)
            ST_IDLE: begin
                // Abort takes priority over a simultaneous start.
                if (start && !abort) begin
                    shift_d = use_def ? DEF_PAT : pattern;
                    hold_d  = use_def ? DEF_PAT : pattern;
                    rep_d   = (count == 4'd0) ? 4'd1 : count;
                    bit_d   = BIT_LAST;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (bit_q == '0) begin
                    if (rep_q > 4'd1) begin
                        // Last bit of a non-final repetition: restart from the
                        // held copy so later pattern input changes cannot leak in.
                        shift_d = hold_q;
                        rep_d   = rep_q - 4'd1;
                        bit_d   = BIT_LAST;
`ifdef SEQ_GEN_GAP_EN
                        state_d = ST_GAP;
`else
                        state_d = ST_SHIFT;
`endif
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    bit_d   = bit_q - BW'(1);
                end
            end

`ifdef SEQ_GEN_GAP_EN
            ST_GAP: begin
                // Shift register was already reloaded on entry; just wait a cycle.
                state_d = abort ? ST_IDLE : ST_SHIFT;
            end
`endif

            ST_DONE: begin
                // Neither start nor abort is honoured here; done always completes.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs, decoded from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        dout       = 1'b0;
        dout_valid = 1'b0;
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        if (state_q == ST_SHIFT) begin
            dout       = shift_q[WIDTH-1];
            dout_valid = 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Purpose : self-checking bench for seq_gen, directed scenarios then random traffic.
// Latency : compares every cycle at the falling edge against a cycle-list reference model.
// Backpr. : n/a.

module tb_seq_gen;

    localparam int          W   = 8;
    localparam logic [W-1:0] DEF = 8'b1010_1010;
`ifdef SEQ_GEN_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst, start, use_def, abort;
    logic [W-1:0] pattern;
    logic [3:0]   count;
    logic         dout, dout_valid, busy, done;

    always #5 clk = ~clk;

    seq_gen #(.WIDTH(W), .DEF_PAT(DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .use_def    (use_def),
        .pattern    (pattern),
        .count      (count),
        .abort      (abort),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    // Expected output for one cycle.
    typedef struct packed {
        logic dout;
        logic vld;
        logic busy;
        logic done;
    } exp_t;

    // Reference model: the whole transmission is expanded into a list of
    // per-cycle outputs at the start edge; the front entry is the current cycle.
    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int vld_cnt  = 0;
    int done_cnt = 0;

    task automatic build_tx(input logic [W-1:0] p, input logic [3:0] c);
        int   reps;
        exp_t e;
        reps = (c == 4'd0) ? 1 : int'(c);
        for (int r = 0; r < reps; r++) begin
            for (int i = W - 1; i >= 0; i--) begin
                e = {p[i], 1'b1, 1'b1, 1'b0};
                exp_q.push_back(e);
            end
            if (GAP_EN && (r < reps - 1)) begin
                e = {1'b0, 1'b0, 1'b1, 1'b0};
                exp_q.push_back(e);
            end
        end
        e = {1'b0, 1'b0, 1'b1, 1'b1};
        exp_q.push_back(e);
    endtask

    // Model reaction to the inputs present at a rising edge.
    task automatic model_edge();
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (start && !abort) build_tx(use_def ? DEF : pattern, count);
        end else if (abort && !exp_q[0].done) begin
            exp_q.delete();
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    task automatic check(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic compare();
        exp_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : exp_t'(4'b0000);
        check("dout",       dout,       e.dout);
        check("dout_valid", dout_valid, e.vld);
        check("busy",       busy,       e.busy);
        check("done",       done,       e.done);
        if (dout_valid === 1'b1) vld_cnt++;
        if (done === 1'b1)       done_cnt++;
    endtask

    // One clock cycle: drive inputs (called at a falling edge), let the edge
    // happen, update the model, then compare at the next falling edge.
    task automatic tick(input logic st, input logic ud, input logic [W-1:0] pat,
                        input logic [3:0] cnt, input logic ab, input logic rs);
        start   = st;
        use_def = ud;
        pattern = pat;
        count   = cnt;
        abort   = ab;
        rst     = rs;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        compare();
    endtask

    // Idle cycles with noisy data inputs that must not disturb a running stream.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            tick(1'b0, 1'($urandom), W'($urandom), 4'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; use_def = 0; pattern = '0; count = '0; abort = 0; rst = 1;
        @(negedge clk);

        // Reset state, with start asserted alongside reset.
        tick(1'b1, 1'b1, 8'hFF, 4'd3, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);

        // Default pattern, single repetition.
        vld_cnt = 0; done_cnt = 0;
        tick(1'b1, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0);
        idle(11);
        check_int("def_valid_cycles", vld_cnt, 8);
        check_int("def_done_pulses",  done_cnt, 1);

        // count=0 behaves as count=1.
        vld_cnt = 0; done_cnt = 0;
        tick(1'b1, 1'b0, 8'hC3, 4'd0, 1'b0, 1'b0);
        idle(11);
        check_int("cnt0_valid_cycles", vld_cnt, 8);
        check_int("cnt0_done_pulses",  done_cnt, 1);

        // Three repetitions; total valid cycles WIDTH*3.
        vld_cnt = 0; done_cnt = 0;
        tick(1'b1, 1'b0, 8'hAA, 4'd3, 1'b0, 1'b0);
        idle(30);
        check_int("rep3_valid_cycles", vld_cnt, 24);
        check_int("rep3_done_pulses",  done_cnt, 1);

        // Start re-asserted mid-stream with a new pattern is ignored.
        tick(1'b1, 1'b0, 8'h35, 4'd1, 1'b0, 1'b0);
        idle(3);
        tick(1'b1, 1'b0, 8'hFF, 4'd5, 1'b0, 1'b0);
        idle(8);

        // Abort in cycle 4, then a normal start.
        done_cnt = 0;
        tick(1'b1, 1'b0, 8'h5A, 4'd2, 1'b0, 1'b0);
        idle(3);
        tick(1'b0, 1'b0, 8'h5A, 4'd2, 1'b1, 1'b0);
        idle(20);
        check_int("abort_done_pulses", done_cnt, 0);
        vld_cnt = 0;
        tick(1'b1, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0);
        idle(11);
        check_int("post_abort_valid", vld_cnt, 8);

        // Abort together with start in IDLE: stays idle.
        tick(1'b1, 1'b0, 8'hF0, 4'd1, 1'b1, 1'b0);
        idle(2);

        // Reset in cycle 5 with count=2, start held high with reset.
        done_cnt = 0;
        tick(1'b1, 1'b0, 8'h96, 4'd2, 1'b0, 1'b0);
        idle(4);
        tick(1'b1, 1'b0, 8'h96, 4'd2, 1'b0, 1'b1);
        idle(20);
        check_int("rst_done_pulses", done_cnt, 0);

        // Start presented during the done cycle is ignored.
        tick(1'b1, 1'b0, 8'h81, 4'd1, 1'b0, 1'b0);
        idle(8);
        tick(1'b1, 1'b0, 8'h7E, 4'd1, 1'b0, 1'b0);
        idle(3);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 99) < 30,
                 1'($urandom),
                 W'($urandom),
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 2,
                 $urandom_range(0, 299) < 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, pattern length in bits (2..32).
REQ-002 SHALL have parameter DEF_PAT, default 8'b1010_1010, pattern sent when use_def is high.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request to begin transmission, sampled only in IDLE.
REQ-006 SHALL have port use_def  input  1  at start: 1 selects DEF_PAT, 0 selects pattern.
REQ-007 SHALL have port pattern  input  WIDTH  pattern to transmit, MSB first.
REQ-008 SHALL have port count  input  4  number of repetitions; 0 treated as 1.
REQ-009 SHALL have port abort  input  1  cancels transmission in progress.
REQ-010 SHALL have port dout  output  1  serial data bit.
REQ-011 SHALL have port dout_valid  output  1  dout carries a pattern bit this cycle.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last bit of the last repetition.

Function
REQ-014 SHALL be a Moore machine: all outputs decoded from registered state only, no combinational path from any input to any output.
REQ-015 SHALL implement states IDLE, SHIFT, GAP, DONE.
REQ-016 IDLE: start=1 and abort=0 at edge N latch the selected pattern into the shift register and a hold copy, load the repetition counter with max(count,1), load the bit counter with WIDTH-1, and enter SHIFT; first bit on dout in cycle N+1 (1-cycle latency).
REQ-017 SHIFT: dout = shift register MSB, dout_valid=1; each edge shifts left by one and decrements the bit counter.
REQ-018 SHIFT with bit counter 0 and repetitions remaining >1: reload shift register from the hold copy, decrement repetitions, reset bit counter, next state GAP (macro defined) or SHIFT (macro undefined).
REQ-019 SHIFT with bit counter 0 and repetitions remaining 1: next state DONE.
REQ-020 GAP: lasts exactly one cycle, dout=0, dout_valid=0, busy=1, then SHIFT.
REQ-021 DONE: done=1, busy=1, dout_valid=0 for exactly one cycle, then IDLE; start in DONE SHALL be ignored.
REQ-022 In IDLE, GAP and DONE, dout SHALL be 0.
REQ-023 start while busy SHALL be ignored; pattern, use_def and count changes after the start edge SHALL NOT affect the transmission.
REQ-024 abort=1 in SHIFT or GAP SHALL return to IDLE at that edge with no done pulse; abort in DONE SHALL be ignored (done completes).
REQ-025 start and abort both high in IDLE: abort wins, machine stays IDLE.
REQ-026 Total valid cycles per transmission SHALL equal WIDTH*max(count,1).

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, clear shift register, hold copy and counters, and drive dout=0, dout_valid=0, busy=0, done=0 from the following cycle, overriding start and abort.
REQ-028 Reset mid-transmission SHALL truncate output immediately with no done pulse.

Configuration
REQ-029 Macro SEQ_GEN_GAP_EN defined: GAP state compiled in, one idle cycle between consecutive repetitions.
REQ-030 Macro SEQ_GEN_GAP_EN undefined: GAP state absent, repetitions back-to-back with dout_valid continuously high.

Verification
REQ-031 use_def=1, count=1, start pulse at edge 0 -> dout 1,0,1,0,1,0,1,0 in cycles 1..8 with dout_valid=1, done=1 in cycle 9, busy=0 in cycle 10.
REQ-032 use_def=0, pattern=8'hC3, count=0 -> identical to count=1: 1,1,0,0,0,0,1,1 in cycles 1..8, done in cycle 9.
REQ-033 pattern=8'hAA, count=3 -> without SEQ_GEN_GAP_EN 24 contiguous valid cycles, done in cycle 25; with it, valid low in cycles 9 and 18, done in cycle 27.
REQ-034 start re-asserted in cycle 4 with pattern=8'hFF -> ignored, original stream continues unchanged.
REQ-035 abort in cycle 4 -> dout_valid=0 and busy=0 from cycle 5, done never asserted; next start works normally.
REQ-036 rst in cycle 5 with count=2 -> all outputs 0 from cycle 6; start together with rst is ignored.
